alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_rf.sv | 41 ++++
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq sequencer: ALU ctrl encodings, FSM states,
// instruction field positions and register-file geometry.
package alu_pkg;

  localparam logic [2:0] ALU_ADDSUB  = 3'b000;
  localparam logic [2:0] ALU_NORNAND = 3'b001;
  localparam logic [2:0] ALU_SLTU    = 3'b010;
  localparam logic [2:0] ALU_SHL_R   = 3'b011;
  localparam logic [2:0] ALU_SRA     = 3'b100;

  localparam int INSTR_W   = 16;
  localparam int CTRL_LSB  = 13;
  localparam int FLAG_BIT  = 12;
  localparam int RD_LSB    = 9;
  localparam int RS1_LSB   = 6;
  localparam int RS2_LSB   = 3;

  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
    case (ctrl)
      ALU_ADDSUB, ALU_NORNAND, ALU_SLTU, ALU_SHL_R, ALU_SRA: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// 8-entry register file: one write port, two operand read ports, one debug
// read port; optional hardwired-zero r0.
module alu_seq_rf
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [RF_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [RF_ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0]    o_rdata1,
  input  logic [RF_ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]    o_rdata2,
  input  logic [RF_ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0]    o_dbg_rdata
);

  logic [DATA_W-1:0] r_mem [RF_DEPTH];
  logic              w_drop;

  assign w_drop = (ZERO_REG != 0) && (i_waddr == '0);

  // NOTE: this array is reset on purpose (the block must come out of reset with
  // every entry at zero), which rules out mapping it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && !w_drop) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1    = ((ZERO_REG != 0) && (i_raddr1 == '0))   ? '0 : r_mem[i_raddr1];
  assign o_rdata2    = ((ZERO_REG != 0) && (i_raddr2 == '0))   ? '0 : r_mem[i_raddr2];
  assign o_dbg_rdata = ((ZERO_REG != 0) && (i_dbg_addr == '0)) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle instruction sequencer driving an external combinational ALU.
// Optional feature: define ALU_SEQ_OVF_TRAP_EN to trap on add/sub overflow.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [DATA_W-1:0]    alu_rs1,
  output logic [DATA_W-1:0]    alu_rs2,
  output logic [2:0]           alu_ctrl,
  output logic                 alu_flag,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_overflow,
  output logic                 wb_valid,
  output logic [RF_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_overflow,
  output logic                 illegal,
  output logic                 trap,
  output logic                 ovf_sticky,
  input  logic                 dbg_we,
  input  logic [RF_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]    dbg_wdata,
  output logic [DATA_W-1:0]    dbg_rdata
);

  state_e r_state, w_next_state;

  logic [2:0]           r_dec_ctrl;
  logic                 r_dec_flag;
  logic [RF_ADDR_W-1:0] r_dec_rd, r_dec_rs1, r_dec_rs2;

  logic [DATA_W-1:0]    r_alu_rs1, r_alu_rs2;
  logic [2:0]           r_alu_ctrl;
  logic                 r_alu_flag;

  logic                 r_wb_valid, r_wb_ovf, r_trap, r_illegal, r_ovf_sticky;
  logic [RF_ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]    r_wb_data;

  logic                 w_accept, w_ovf_now, w_trap_cond;
  logic                 w_rf_we, w_wb_we;
  logic [RF_ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0]    w_rf_wdata, w_rs1_data, w_rs2_data;
  logic                 w_unused_instr;

  assign w_unused_instr = ^instr[RS2_LSB-1:0];

  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_ready && instr_valid;
  assign w_ovf_now   = (r_alu_ctrl == ALU_ADDSUB) && alu_overflow;

`ifdef ALU_SEQ_OVF_TRAP_EN
  assign w_trap_cond = w_ovf_now;
`else
  assign w_trap_cond = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid)  w_next_state = S_DECODE;
      S_DECODE: w_next_state = is_legal_ctrl(r_dec_ctrl) ? S_EXEC : S_IDLE;
      S_EXEC:   w_next_state = S_WB;
      S_WB:     w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_ctrl   <= '0;
      r_dec_flag   <= 1'b0;
      r_dec_rd     <= '0;
      r_dec_rs1    <= '0;
      r_dec_rs2    <= '0;
      r_alu_rs1    <= '0;
      r_alu_rs2    <= '0;
      r_alu_ctrl   <= '0;
      r_alu_flag   <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_wb_ovf     <= 1'b0;
      r_trap       <= 1'b0;
      r_illegal    <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_trap     <= 1'b0;
      r_illegal  <= 1'b0;

      if (w_accept) begin
        r_dec_ctrl <= instr[CTRL_LSB +: 3];
        r_dec_flag <= instr[FLAG_BIT];
        r_dec_rd   <= instr[RD_LSB  +: RF_ADDR_W];
        r_dec_rs1  <= instr[RS1_LSB +: RF_ADDR_W];
        r_dec_rs2  <= instr[RS2_LSB +: RF_ADDR_W];
      end

      if (r_state == S_DECODE) begin
        r_alu_rs1  <= w_rs1_data;
        r_alu_rs2  <= w_rs2_data;
        r_alu_ctrl <= r_dec_ctrl;
        r_alu_flag <= r_dec_flag;
        r_illegal  <= !is_legal_ctrl(r_dec_ctrl);
      end

      // Result is captured at the end of EXEC so WB presents registered values.
      if (r_state == S_EXEC) begin
        r_wb_data  <= alu_out;
        r_wb_rd    <= r_dec_rd;
        r_wb_ovf   <= w_ovf_now;
        r_wb_valid <= !w_trap_cond;
        r_trap     <= w_trap_cond;
        if (w_ovf_now) r_ovf_sticky <= 1'b1;
      end
    end
  end

  // WB owns the write port in WB; debug writes are honoured only in IDLE.
  assign w_wb_we    = (r_state == S_WB) && r_wb_valid;
  assign w_rf_we    = w_wb_we || ((r_state == S_IDLE) && dbg_we);
  assign w_rf_waddr = w_wb_we ? r_wb_rd   : dbg_addr;
  assign w_rf_wdata = w_wb_we ? r_wb_data : dbg_wdata;

  alu_seq_rf #(
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) u_rf (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_rf_we),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .i_raddr1    (r_dec_rs1),
    .o_rdata1    (w_rs1_data),
    .i_raddr2    (r_dec_rs2),
    .o_rdata2    (w_rs2_data),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_rdata (dbg_rdata)
  );

  assign alu_rs1     = r_alu_rs1;
  assign alu_rs2     = r_alu_rs2;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_flag    = r_alu_flag;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign wb_overflow = r_wb_ovf;
  assign illegal     = r_illegal;
  assign trap        = r_trap;
  assign ovf_sticky  = r_ovf_sticky;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; includes a behavioural ALU on the
// operand interface. Expectations switch when ALU_SEQ_OVF_TRAP_EN is defined.
module tb_alu_seq;

`ifdef ALU_SEQ_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_rs1, alu_rs2, alu_out;
  logic [2:0]  alu_ctrl;
  logic        alu_flag, alu_overflow;
  logic        wb_valid, wb_overflow;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic        illegal, trap, ovf_sticky;
  logic        dbg_we;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_wdata, dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wb_count = 0;
  int base;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl), .alu_flag(alu_flag),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_overflow(wb_overflow),
    .illegal(illegal), .trap(trap), .ovf_sticky(ovf_sticky),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // External ALU. Non-add ops raise overflow so the DUT's masking is exercised.
  logic [7:0] bm_sum;
  always_comb begin
    bm_sum       = alu_flag ? (alu_rs1 - alu_rs2) : (alu_rs1 + alu_rs2);
    alu_out      = 8'h00;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      3'b000: begin
        alu_out      = bm_sum;
        alu_overflow = alu_flag ? ((alu_rs1[7] != alu_rs2[7]) && (bm_sum[7] != alu_rs1[7]))
                                : ((alu_rs1[7] == alu_rs2[7]) && (bm_sum[7] != alu_rs1[7]));
      end
      3'b001:  alu_out = alu_flag ? ~(alu_rs1 & alu_rs2) : ~(alu_rs1 | alu_rs2);
      3'b010:  alu_out = (alu_rs1 < alu_rs2) ? 8'h01 : 8'h00;
      3'b011:  alu_out = alu_flag ? (alu_rs1 >> alu_rs2[2:0]) : (alu_rs1 << alu_rs2[2:0]);
      3'b100:  alu_out = 8'($signed(alu_rs1) >>> alu_rs2[2:0]);
      default: alu_out = 8'h00;
    endcase
  end

  always @(negedge clk) if (wb_valid) wb_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] c, input logic f,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2);
    return {c, f, rd, rs1, rs2, 3'b000};
  endfunction

  task automatic dbg_write(input logic [2:0] a, input logic [7:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic check_rf(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle N+4.
  task automatic run_op(input string tag, input logic [15:0] ins, input logic exp_valid,
                        input logic [7:0] exp_data, input logic exp_ovf, input logic exp_trap);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; dbg_we = 1'b0;
    check({tag, "/n1_wb_valid"}, wb_valid, 0);
    check({tag, "/n1_ready"}, instr_ready, 0);
    @(negedge clk);
    check({tag, "/n2_wb_valid"}, wb_valid, 0);
    @(negedge clk);
    check({tag, "/n3_wb_valid"}, wb_valid, exp_valid);
    check({tag, "/n3_wb_data"}, wb_data, exp_data);
    check({tag, "/n3_wb_ovf"}, wb_overflow, exp_ovf);
    check({tag, "/n3_trap"}, trap, exp_trap);
    @(negedge clk);
    check({tag, "/n4_wb_valid"}, wb_valid, 0);
    check({tag, "/n4_ready"}, instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    dbg_we = 1'b0; dbg_addr = 3'd0; dbg_wdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst/ready", instr_ready, 1);
    check("rst/wb_valid", wb_valid, 0);
    check("rst/illegal", illegal, 0);
    check("rst/trap", trap, 0);
    check("rst/sticky", ovf_sticky, 0);
    check("rst/alu_rs1", alu_rs1, 0);
    check_rf("rst/r3", 3'd3, 8'h00);

    // 0x0F + 0x0A
    dbg_write(3'd1, 8'h0F);
    dbg_write(3'd2, 8'h0A);
    check_rf("dbg/r1", 3'd1, 8'h0F);
    run_op("add", mk(3'b000, 1'b0, 3'd3, 3'd1, 3'd2), 1'b1, 8'h19, 1'b0, 1'b0);
    check("add/alu_rs1", alu_rs1, 8'h0F);
    check("add/alu_rs2", alu_rs2, 8'h0A);
    check("add/alu_ctrl", alu_ctrl, 3'b000);
    check("add/sticky", ovf_sticky, 0);
    check_rf("add/r3", 3'd3, 8'h19);

    // Signed overflow: 0x82 + 0x82
    dbg_write(3'd1, 8'h82);
    dbg_write(3'd2, 8'h82);
    run_op("ovf", mk(3'b000, 1'b0, 3'd3, 3'd1, 3'd2), !TRAP_EN, 8'h04, 1'b1, TRAP_EN);
    check("ovf/sticky", ovf_sticky, 1);
    check_rf("ovf/r3", 3'd3, TRAP_EN ? 8'h19 : 8'h04);

    // Subtract, shift-left, then back-to-back dependent add
    dbg_write(3'd1, 8'h0A);
    dbg_write(3'd2, 8'h0F);
    run_op("sub", mk(3'b000, 1'b1, 3'd4, 3'd1, 3'd2), 1'b1, 8'hFB, 1'b0, 1'b0);
    check("sub/alu_flag", alu_flag, 1);
    dbg_write(3'd1, 8'h0F);
    dbg_write(3'd2, 8'h02);
    run_op("sll", mk(3'b011, 1'b0, 3'd5, 3'd1, 3'd2), 1'b1, 8'h3C, 1'b0, 1'b0);
    run_op("b2b", mk(3'b000, 1'b0, 3'd6, 3'd5, 3'd5), 1'b1, 8'h78, 1'b0, 1'b0);
    check("b2b/sticky", ovf_sticky, 1);

    // Remaining ctrl encodings
    run_op("nor",  mk(3'b001, 1'b0, 3'd7, 3'd1, 3'd2), 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sltu", mk(3'b010, 1'b0, 3'd7, 3'd2, 3'd1), 1'b1, 8'h01, 1'b0, 1'b0);
    run_op("sra",  mk(3'b100, 1'b0, 3'd7, 3'd4, 3'd2), 1'b1, 8'hFE, 1'b0, 1'b0);
    check_rf("sra/r7", 3'd7, 8'hFE);

    // r0 is hardwired to zero
    dbg_write(3'd1, 8'h01);
    run_op("r0", mk(3'b000, 1'b0, 3'd0, 3'd1, 3'd1), 1'b1, 8'h02, 1'b0, 1'b0);
    check_rf("r0/after_wb", 3'd0, 8'h00);
    dbg_write(3'd0, 8'h55);
    check_rf("r0/after_dbg", 3'd0, 8'h00);

    // Illegal ctrl
    base = wb_count;
    instr = mk(3'b111, 1'b0, 3'd7, 3'd1, 3'd1); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill/n1_illegal", illegal, 0);
    check("ill/n1_ready", instr_ready, 0);
    @(negedge clk);
    check("ill/n2_illegal", illegal, 1);
    check("ill/n2_ready", instr_ready, 1);
    @(negedge clk);
    check("ill/n3_illegal", illegal, 0);
    @(negedge clk);
    check("ill/wb_count", wb_count - base, 0);
    check_rf("ill/r7", 3'd7, 8'hFE);

    // Debug write coinciding with an accepted instruction lands first
    dbg_we = 1'b1; dbg_addr = 3'd1; dbg_wdata = 8'h11;
    run_op("coinc", mk(3'b000, 1'b0, 3'd2, 3'd1, 3'd1), 1'b1, 8'h22, 1'b0, 1'b0);
    check_rf("coinc/r2", 3'd2, 8'h22);

    // instr_valid held while busy, debug writes while busy
    base = wb_count;
    instr = mk(3'b000, 1'b0, 3'd6, 3'd1, 3'd1); instr_valid = 1'b1;
    @(negedge clk);
    instr = mk(3'b000, 1'b0, 3'd7, 3'd4, 3'd4);
    dbg_we = 1'b1; dbg_addr = 3'd5; dbg_wdata = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    check("hold/wb_rd", wb_rd, 3'd6);
    check("hold/wb_data", wb_data, 8'h22);
    instr_valid = 1'b0; dbg_we = 1'b0;
    repeat (4) @(negedge clk);
    check("hold/wb_count", wb_count - base, 1);
    check_rf("hold/r5", 3'd5, 8'h3C);
    check_rf("hold/r6", 3'd6, 8'h22);
    check_rf("hold/r7", 3'd7, 8'hFE);

    // Reset during EXEC abandons the instruction
    base = wb_count;
    dbg_write(3'd1, 8'h82);
    instr = mk(3'b000, 1'b0, 3'd3, 3'd1, 3'd1); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstx/wb_valid", wb_valid, 0);
    check("rstx/sticky", ovf_sticky, 0);
    check("rstx/alu_rs1", alu_rs1, 0);
    check("rstx/wb_data", wb_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rstx/ready", instr_ready, 1);
    repeat (3) @(negedge clk);
    check("rstx/wb_count", wb_count - base, 0);
    for (int i = 0; i < 8; i++) check_rf($sformatf("rstx/r%0d", i), 3'(i), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
